// File: rtl/input_load_debouncer.sv
// input_load_debouncer
// Debounces a bouncing load pushbutton and produces a single-cycle load
// strobe carrying the slide-switch value, clamped to MAX_VALUE.
// Both raw inputs are brought into the clock domain through two-flop
// synchronizers. All outputs are registered.

module input_load_debouncer #(
    parameter int DEBOUNCE_CYCLES = 20,
    parameter int MAX_VALUE       = 9
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       btn_load,
    input  logic [3:0] value_in,
    output logic       load,
    output logic [3:0] load_ref_value,
    output logic       clamped,
    output logic       busy
);

    localparam int               CNT_W       = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_TERM    = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX     = {CNT_W{1'b1}};
    localparam logic [3:0]       VALUE_LIMIT = 4'(MAX_VALUE);

    localparam logic [1:0] ST_IDLE         = 2'd0;
    localparam logic [1:0] ST_PRESS_WAIT   = 2'd1;
    localparam logic [1:0] ST_HELD         = 2'd2;
    localparam logic [1:0] ST_RELEASE_WAIT = 2'd3;

    // Returns {clamp_flag, limited_value} for a captured switch value.
    function automatic logic [4:0] clamp_value(input logic [3:0] v);
        logic [4:0] res;
        if (v > VALUE_LIMIT) begin
            res = {1'b1, VALUE_LIMIT};
        end else begin
            res = {1'b0, v};
        end
        return res;
    endfunction

    logic             r_btn_meta;
    logic             r_btn_sync;
    logic [3:0]       r_val_meta;
    logic [3:0]       r_val_sync;
    logic [1:0]       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_load;
    logic [3:0]       r_ref;
    logic             r_clamped;
    logic             r_busy;

    logic [1:0]       w_state_nxt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [CNT_W-1:0] w_cnt_inc;
    logic             w_strobe;
    logic [4:0]       w_clamp;

    // Two-flop synchronizers for the raw button and switch inputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_btn_meta <= 1'b0;
            r_btn_sync <= 1'b0;
            r_val_meta <= 4'd0;
            r_val_sync <= 4'd0;
        end else begin
            r_btn_meta <= btn_load;
            r_btn_sync <= r_btn_meta;
            r_val_meta <= value_in;
            r_val_sync <= r_val_meta;
        end
    end

    // Saturating increment so the debounce counter can never wrap.
    always_comb begin
        w_cnt_inc = r_cnt;
        if (r_cnt == CNT_MAX) begin
            w_cnt_inc = r_cnt;
        end else begin
            w_cnt_inc = r_cnt + CNT_W'(1);
        end
    end

    // Next-state, next-count and strobe decision for the debounce FSM.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_strobe    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (r_btn_sync) begin
                    w_state_nxt = ST_PRESS_WAIT;
                    w_cnt_nxt   = '0;
                end else begin
                    w_state_nxt = ST_IDLE;
                    w_cnt_nxt   = '0;
                end
            end
            ST_PRESS_WAIT: begin
                if (!r_btn_sync) begin
                    // Bounce during press: abandon without a strobe.
                    w_state_nxt = ST_IDLE;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == CNT_TERM) begin
                    w_state_nxt = ST_HELD;
                    w_cnt_nxt   = '0;
                    w_strobe    = 1'b1;
                end else begin
                    w_state_nxt = ST_PRESS_WAIT;
                    w_cnt_nxt   = w_cnt_inc;
                end
            end
            ST_HELD: begin
                if (!r_btn_sync) begin
                    w_state_nxt = ST_RELEASE_WAIT;
                    w_cnt_nxt   = '0;
                end else begin
                    w_state_nxt = ST_HELD;
                    w_cnt_nxt   = '0;
                end
            end
            ST_RELEASE_WAIT: begin
                if (r_btn_sync) begin
                    // Bounce on release: back to held, no new strobe.
                    w_state_nxt = ST_HELD;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == CNT_TERM) begin
                    w_state_nxt = ST_IDLE;
                    w_cnt_nxt   = '0;
                end else begin
                    w_state_nxt = ST_RELEASE_WAIT;
                    w_cnt_nxt   = w_cnt_inc;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    assign w_clamp = clamp_value(r_val_sync);

    // State, counter and registered outputs; value only updates on a strobe.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state   <= ST_IDLE;
            r_cnt     <= '0;
            r_load    <= 1'b0;
            r_ref     <= 4'd0;
            r_clamped <= 1'b0;
            r_busy    <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_load  <= w_strobe;
            r_busy  <= (w_state_nxt != ST_IDLE);
            if (w_strobe) begin
                r_ref     <= w_clamp[3:0];
                r_clamped <= w_clamp[4];
            end else begin
                r_ref     <= r_ref;
                r_clamped <= 1'b0;
            end
        end
    end

    assign load           = r_load;
    assign load_ref_value = r_ref;
    assign clamped        = r_clamped;
    assign busy           = r_busy;

endmodule

// File: tb/tb_input_load_debouncer.sv
// Self-checking bench for input_load_debouncer (DEBOUNCE_CYCLES=4 main
// instance, plus a DEBOUNCE_CYCLES=1 instance sharing the same inputs).
// Inputs are driven on the falling edge; outputs are sampled 1 ns after
// the rising edge. Row k's expected outputs are those seen after edge k.

module tb_input_load_debouncer;

    typedef struct {
        int         id;
        logic       rst;
        logic       btn;
        logic [3:0] val;
        logic       e_load;
        logic [3:0] e_ref;
        logic       e_clamp;
        logic       e_busy;
    } vec_t;

    logic       clock;
    logic       reset;
    logic       btn_load;
    logic [3:0] value_in;
    logic       load;
    logic [3:0] load_ref_value;
    logic       clamped;
    logic       busy;
    logic       load1;
    logic [3:0] ref1;
    logic       clamped1;
    logic       busy1;

    vec_t tbl[$];
    vec_t exp_q[$];
    int   n_vec;
    int   n_fail;

    input_load_debouncer #(.DEBOUNCE_CYCLES(4), .MAX_VALUE(9)) dut (
        .clock          (clock),
        .reset          (reset),
        .btn_load       (btn_load),
        .value_in       (value_in),
        .load           (load),
        .load_ref_value (load_ref_value),
        .clamped        (clamped),
        .busy           (busy)
    );

    input_load_debouncer #(.DEBOUNCE_CYCLES(1), .MAX_VALUE(9)) dut1 (
        .clock          (clock),
        .reset          (reset),
        .btn_load       (btn_load),
        .value_in       (value_in),
        .load           (load1),
        .load_ref_value (ref1),
        .clamped        (clamped1),
        .busy           (busy1)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic add(input int id, input logic rst, input logic btn, input logic [3:0] val,
                       input logic el, input logic [3:0] er, input logic ec, input logic eb);
        vec_t v;
        v.id = id; v.rst = rst; v.btn = btn; v.val = val;
        v.e_load = el; v.e_ref = er; v.e_clamp = ec; v.e_busy = eb;
        tbl.push_back(v);
    endtask

    // Clean press from idle: strobe 6 rows after the first high row.
    task automatic add_press(input int id, input logic [3:0] val, input logic [3:0] ref_before,
                             input logic [3:0] ref_after, input logic clamp_after);
        for (int k = 0; k < 8; k++) begin
            add(id, 1'b0, 1'b1, val,
                (k == 6),
                (k >= 6) ? ref_after : ref_before,
                (k == 6) ? clamp_after : 1'b0,
                (k >= 2));
        end
    endtask

    // Clean release from held: idle 6 rows after the first low row.
    task automatic add_release(input int id, input logic [3:0] val, input logic [3:0] ref_now);
        for (int k = 0; k < 8; k++) begin
            add(id, 1'b0, 1'b0, val, 1'b0, ref_now, 1'b0, (k < 6));
        end
    endtask

    task automatic apply(input vec_t v);
        vec_t e;
        @(negedge clock);
        reset    = v.rst;
        btn_load = v.btn;
        value_in = v.val;
        exp_q.push_back(v);
        @(posedge clock);
        #1;
        n_vec++;
        if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL scoreboard_empty vec=%0d", n_vec);
        end else begin
            e = exp_q.pop_front();
            if (load !== e.e_load || load_ref_value !== e.e_ref ||
                clamped !== e.e_clamp || busy !== e.e_busy) begin
                n_fail++;
                $display("FAIL case%0d vec=%0d got load=%b ref=%0d clamped=%b busy=%b, need load=%b ref=%0d clamped=%b busy=%b",
                         e.id, n_vec, load, load_ref_value, clamped, busy,
                         e.e_load, e.e_ref, e.e_clamp, e.e_busy);
            end
        end
    endtask

    task automatic apply_one(input int id, input logic rst, input logic btn, input logic [3:0] val,
                             input logic el, input logic [3:0] er, input logic ec, input logic eb);
        vec_t v;
        v.id = id; v.rst = rst; v.btn = btn; v.val = val;
        v.e_load = el; v.e_ref = er; v.e_clamp = ec; v.e_busy = eb;
        apply(v);
    endtask

    task automatic check_dc1(input int row, input logic el, input logic [3:0] er);
        n_vec++;
        if (load1 !== el || ref1 !== er) begin
            n_fail++;
            $display("FAIL dc1_press row=%0d got load=%b ref=%0d, need load=%b ref=%0d",
                     row, load1, ref1, el, er);
        end
    endtask

    initial begin
        int strobes;
        int glitch [16];
        reset    = 1'b1;
        btn_load = 1'b0;
        value_in = 4'd0;
        n_vec    = 0;
        n_fail   = 0;

        // ---- vector table ----
        // case 1: reset state, then clean press with value 5, release
        add(1, 1'b1, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0);
        add(1, 1'b0, 1'b0, 4'd5, 1'b0, 4'd0, 1'b0, 1'b0);
        add(1, 1'b0, 1'b0, 4'd5, 1'b0, 4'd0, 1'b0, 1'b0);
        add_press(1, 4'd5, 4'd0, 4'd5, 1'b0);
        add_release(1, 4'd5, 4'd5);
        // case 2: bouncy press 1,0,1,0 then stable high, value 3
        add(2, 1'b0, 1'b1, 4'd3, 1'b0, 4'd5, 1'b0, 1'b0);
        add(2, 1'b0, 1'b0, 4'd3, 1'b0, 4'd5, 1'b0, 1'b0);
        add(2, 1'b0, 1'b1, 4'd3, 1'b0, 4'd5, 1'b0, 1'b1);
        add(2, 1'b0, 1'b0, 4'd3, 1'b0, 4'd5, 1'b0, 1'b0);
        add(2, 1'b0, 1'b1, 4'd3, 1'b0, 4'd5, 1'b0, 1'b1);
        add(2, 1'b0, 1'b1, 4'd3, 1'b0, 4'd5, 1'b0, 1'b0);
        for (int k = 0; k < 4; k++) add(2, 1'b0, 1'b1, 4'd3, 1'b0, 4'd5, 1'b0, 1'b1);
        add(2, 1'b0, 1'b1, 4'd3, 1'b1, 4'd3, 1'b0, 1'b1);
        add(2, 1'b0, 1'b1, 4'd3, 1'b0, 4'd3, 1'b0, 1'b1);
        // case 3: value changes to 7 while held -> ref stays 3
        for (int k = 0; k < 4; k++) add(3, 1'b0, 1'b1, 4'd7, 1'b0, 4'd3, 1'b0, 1'b1);
        add_release(3, 4'd7, 4'd3);
        // case 4: clamp 0xC -> 9 with clamped for the strobe cycle only
        add_press(4, 4'hC, 4'd3, 4'd9, 1'b1);
        add_release(4, 4'hC, 4'd9);
        // case 5: reset at debounce count 2, then fresh press from idle
        add(5, 1'b0, 1'b1, 4'd6, 1'b0, 4'd9, 1'b0, 1'b0);
        add(5, 1'b0, 1'b1, 4'd6, 1'b0, 4'd9, 1'b0, 1'b0);
        add(5, 1'b0, 1'b1, 4'd6, 1'b0, 4'd9, 1'b0, 1'b1);
        add(5, 1'b0, 1'b1, 4'd6, 1'b0, 4'd9, 1'b0, 1'b1);
        add(5, 1'b0, 1'b1, 4'd6, 1'b0, 4'd9, 1'b0, 1'b1);
        add(5, 1'b1, 1'b1, 4'd6, 1'b0, 4'd0, 1'b0, 1'b0);
        add_press(5, 4'd6, 4'd0, 4'd6, 1'b0);
        add_release(5, 4'd6, 4'd6);
        // case 6: reset while held aborts, still-held button re-debounces
        add_press(6, 4'd2, 4'd6, 4'd2, 1'b0);
        add(6, 1'b1, 1'b1, 4'd4, 1'b0, 4'd0, 1'b0, 1'b0);
        add_press(6, 4'd4, 4'd0, 4'd4, 1'b0);
        add_release(6, 4'd4, 4'd4);

        for (int i = 0; i < tbl.size(); i++) apply(tbl[i]);

        // ---- hand-written: long hold, glitchy release, DC=1 instance ----
        strobes = 0;
        apply_one(10, 1'b1, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0);
        check_dc1(-1, 1'b0, 4'd0);
        for (int k = 0; k < 8; k++) begin
            apply_one(10, 1'b0, 1'b1, 4'd8, (k == 6), (k >= 6) ? 4'd8 : 4'd0, 1'b0, (k >= 2));
            if (load === 1'b1) strobes++;
            check_dc1(k, (k == 3), (k >= 3) ? 4'd8 : 4'd0);
        end
        for (int k = 0; k < 100; k++) begin
            apply_one(11, 1'b0, 1'b1, 4'd1, 1'b0, 4'd8, 1'b0, 1'b1);
            if (load === 1'b1) strobes++;
            if (k % 25 == 0) check_dc1(100 + k, 1'b0, 4'd8);
        end
        glitch = '{0, 0, 1, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0};
        for (int k = 0; k < 16; k++) begin
            apply_one(12, 1'b0, glitch[k][0], 4'd1, 1'b0, 4'd8, 1'b0, (k < 14));
            if (load === 1'b1) strobes++;
        end
        n_vec++;
        if (strobes != 1) begin
            n_fail++;
            $display("FAIL strobe_count got=%0d need=1", strobes);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
